// File: rtl/vpi_mbox_responder_pkg.sv
// Shared types and constants for the VPI mailbox responder.
package vpi_mbox_pkg;

    localparam int unsigned OP_W  = 2;
    localparam int unsigned ST_W  = 2;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [ST_W-1:0] {
        ST_OK       = 2'b00,
        ST_BAD_ADDR = 2'b01,
        ST_BAD_OP   = 2'b10
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_CLR  = 2'b10,
        S_RESP = 2'b11
    } state_e;

    // Clear-index width: wide enough to count to depth, never narrower than 5 bits.
    function automatic int unsigned clr_idx_w(input int unsigned depth);
        int unsigned w;
        w = 32'($clog2(depth + 1));
        return (w < 5) ? 5 : w;
    endfunction

endpackage

// File: rtl/vpi_mbox_responder_if.sv
// Host-facing request/response bundle of the mailbox responder.
interface vpi_mbox_responder_if
    import vpi_mbox_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);

    logic              req_toggle;
    logic [OP_W-1:0]   req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              ack_toggle;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ST_W-1:0]   rsp_status;
    logic              busy;
    logic              overrun;
    logic [CNT_W-1:0]  req_count;

    modport master (
        output req_toggle, req_op, req_addr, req_wdata,
        input  ack_toggle, rsp_rdata, rsp_status, busy, overrun, req_count
    );

    modport slave (
        input  req_toggle, req_op, req_addr, req_wdata,
        output ack_toggle, rsp_rdata, rsp_status, busy, overrun, req_count
    );

endinterface

// File: rtl/vpi_mbox_responder_toggle_detect.sv
// Request-toggle tracker: remembers the last accepted toggle level and flags
// toggle edges that arrive while the responder cannot accept.
module vpi_toggle_detect (
    input  logic clk,
    input  logic rst,
    input  logic tgl_in,
    input  logic accept,
    output logic pending,
    output logic changed_while_busy
);

    logic r_req_seen;
    logic r_tgl_d;

    // Track the accepted level and the previous sample of the host toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_seen <= 1'b0;
            r_tgl_d    <= 1'b0;
        end else begin
            r_tgl_d <= tgl_in;
            if (accept && pending) begin
                r_req_seen <= tgl_in;
            end
        end
    end

    assign pending            = (tgl_in != r_req_seen);
    assign changed_while_busy = !accept && (tgl_in != r_tgl_d);

endmodule

// File: rtl/vpi_mbox_responder.sv
// Design-side responder for host-posted mailbox requests: detects a toggle,
// runs WRITE/READ/CLEAR on mem[], and answers with an ack toggle.
module vpi_mbox_responder
    import vpi_mbox_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    vpi_mbox_responder_if.slave  bus
);

    localparam int unsigned CLR_W = clr_idx_w(DEPTH);
    localparam int unsigned IDX_W = (DEPTH > 1) ? 32'($clog2(DEPTH)) : 1;

    // Kept as plain named variables so VPI can locate them by scope.
    state_e            state;
    logic [DATA_W-1:0] mem [DEPTH];

    state_e            w_state_nxt;
    logic              w_idle;
    logic              w_pending;
    logic              w_changed_busy;
    logic              w_accept;
    logic              w_exec;
    logic              w_clr_step;
    logic              w_clr_last;
    logic              w_resp;
    logic              w_addr_bad;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_mem_rd;

    op_e               r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata_q;
    status_e           r_status_q;
    logic [CLR_W-1:0]  r_clr_idx;
    logic              r_busy;
    logic              r_ack;
    logic              r_overrun;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_rsp_rdata;
    status_e           r_rsp_status;

    assign w_idle     = (state == S_IDLE);
    assign w_addr_bad = (32'(r_addr) >= DEPTH);
    assign w_clr_last = (r_clr_idx == CLR_W'(DEPTH - 1));
    assign w_mem_we   = w_exec && (r_op == OP_WRITE) && !w_addr_bad;
    // Out-of-range indices are never consumed: w_addr_bad masks them.
    assign w_mem_rd   = mem[r_addr[IDX_W-1:0]];

    vpi_toggle_detect u_toggle_detect (
        .clk                (clk),
        .rst                (rst),
        .tgl_in             (bus.req_toggle),
        .accept             (w_idle),
        .pending            (w_pending),
        .changed_while_busy (w_changed_busy)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= w_state_nxt;
        end
    end

    // Next-state and per-phase strobes.
    always_comb begin
        w_state_nxt = state;
        w_accept    = 1'b0;
        w_exec      = 1'b0;
        w_clr_step  = 1'b0;
        w_resp      = 1'b0;
        case (state)
            S_IDLE: begin
                if (w_pending) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = (r_op == OP_CLEAR) ? S_CLR : S_RESP;
            end
            S_CLR: begin
                w_clr_step = 1'b1;
                if (w_clr_last) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_resp      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latch the request on accept; busy spans accept to ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= OP_NOP;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= op_e'(bus.req_op);
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_busy  <= 1'b1;
            end else if (w_resp) begin
                r_busy  <= 1'b0;
            end
        end
    end

    // Execute phase result capture and clear-index sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata_q  <= '0;
            r_status_q <= ST_OK;
            r_clr_idx  <= '0;
        end else begin
            if (w_exec) begin
                r_rdata_q  <= '0;
                r_status_q <= ST_OK;
                r_clr_idx  <= '0;
                if (r_op != OP_CLEAR && w_addr_bad) begin
                    r_status_q <= ST_BAD_ADDR;
                end else if (r_op == OP_READ) begin
                    r_rdata_q  <= w_mem_rd;
                end
            end else if (w_clr_step) begin
                r_clr_idx <= r_clr_idx + CLR_W'(1);
            end
        end
    end

    // Response publish: data, status, ack flip and count move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_rdata  <= '0;
            r_rsp_status <= ST_OK;
            r_ack        <= 1'b0;
            r_count      <= '0;
        end else if (w_resp) begin
            r_rsp_rdata  <= r_rdata_q;
            r_rsp_status <= r_status_q;
            r_ack        <= ~r_ack;
            r_count      <= r_count + CNT_W'(1);
        end
    end

    // Sticky record of host toggles lost while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_changed_busy) begin
            r_overrun <= 1'b1;
        end
    end

    // Storage: one register per entry; clear sweep and write never overlap.
    for (genvar g = 0; g < DEPTH; g++) begin : g_mem
        // Entry g: cleared by reset or the sweep, loaded by an in-range WRITE.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem[g] <= '0;
            end else if (w_clr_step && (r_clr_idx == CLR_W'(g))) begin
                mem[g] <= '0;
            end else if (w_mem_we && (r_addr == ADDR_W'(g))) begin
                mem[g] <= r_wdata;
            end
        end
    end

    assign bus.ack_toggle = r_ack;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.rsp_status = r_rsp_status;
    assign bus.busy       = r_busy;
    assign bus.overrun    = r_overrun;
    assign bus.req_count  = r_count;

endmodule

// File: tb/tb_vpi_mbox_responder.sv
// Self-checking bench for vpi_mbox_responder: directed table, random traffic
// against a transaction-level model, and hand-written overrun/reset sequences.
module tb_vpi_mbox_responder;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 12;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] WR  = 2'b01;
    localparam logic [1:0] RD  = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    // Ticks from posting a request to seeing its ack, sampling 1ns after edges.
    localparam int LAT_OP  = 3;
    localparam int LAT_CLR = 3 + DEPTH;

    typedef struct packed {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_status;
        logic [31:0] exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic r_tgl;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_mem [16];
    logic [15:0] m_count;
    logic        m_ack;
    logic        m_ovr;

    vec_t vecs[$];

    vpi_mbox_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vpi_mbox_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic post(input logic [1:0] op, input logic [3:0] addr, input logic [31:0] wd);
        bus.req_op     = op;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        r_tgl          = ~r_tgl;
        bus.req_toggle = r_tgl;
    endtask

    task automatic flip_only();
        r_tgl          = ~r_tgl;
        bus.req_toggle = r_tgl;
    endtask

    // Wait for ack to leave 'old'; lat is incremented per tick, bounded.
    task automatic wait_ack(input logic old, inout int lat);
        while (bus.ack_toggle === old && lat < 300) begin
            tick();
            lat++;
        end
    endtask

    task automatic chk_counts(input string name);
        chk({name, "_count"},   32'(bus.req_count),  32'(m_count));
        chk({name, "_ack"},     32'(bus.ack_toggle), 32'(m_ack));
        chk({name, "_overrun"}, 32'(bus.overrun),    32'(m_ovr));
    endtask

    // One full request with expectations for result, status and latency.
    task automatic do_req(input string name, input logic [1:0] op, input logic [3:0] addr,
                          input logic [31:0] wd, input logic [31:0] er,
                          input logic [1:0] es, input int el);
        logic old;
        int   lat;
        old = bus.ack_toggle;
        post(op, addr, wd);
        tick();
        lat = 1;
        chk({name, "_busy_hi"}, 32'(bus.busy), 32'd1);
        wait_ack(old, lat);
        m_count = m_count + 16'd1;
        m_ack   = ~m_ack;
        chk({name, "_lat"},     32'(lat),            32'(el));
        chk({name, "_rdata"},   bus.rsp_rdata,       er);
        chk({name, "_status"},  32'(bus.rsp_status), 32'(es));
        chk({name, "_busy_lo"}, 32'(bus.busy),       32'd0);
        chk_counts(name);
    endtask

    // Transaction-level reference: what a request does to the mailbox.
    task automatic model_req(input logic [1:0] op, input logic [3:0] addr, input logic [31:0] wd,
                             output logic [31:0] er, output logic [1:0] es, output int el);
        er = 32'd0;
        es = 2'd0;
        el = LAT_OP;
        if (op == CLR) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 32'd0;
            el = LAT_CLR;
        end else if (32'(addr) >= DEPTH) begin
            es = 2'd1;
        end else if (op == WR) begin
            m_mem[addr] = wd;
        end else if (op == RD) begin
            er = m_mem[addr];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 32'd0;
        m_count = 16'd0;
        m_ack   = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ack"},     32'(bus.ack_toggle), 32'd0);
        chk({name, "_rdata"},   bus.rsp_rdata,       32'd0);
        chk({name, "_status"},  32'(bus.rsp_status), 32'd0);
        chk({name, "_busy"},    32'(bus.busy),       32'd0);
        chk({name, "_overrun"}, 32'(bus.overrun),    32'd0);
        chk({name, "_count"},   32'(bus.req_count),  32'd0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            chk($sformatf("%s_mem%0d", name, i), dut.mem[i], 32'd0);
        end
    endtask

    function automatic void add_vec(input logic [1:0] op, input logic [3:0] addr,
                                    input logic [31:0] wd, input logic [31:0] er,
                                    input logic [1:0] es, input int el);
        vecs.push_back(vec_t'{op, addr, wd, er, es, 32'(el)});
    endfunction

    initial begin
        logic [31:0] er;
        logic [1:0]  es;
        int          el;
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic        old;
        int          lat;
        int          r;

        // Directed table: WRITE/READ, bad address, fill, CLEAR, readback.
        add_vec(WR, 4'd3,  32'hDEADBEEF, 32'h0,        2'd0, LAT_OP);
        add_vec(RD, 4'd3,  32'h0,        32'hDEADBEEF, 2'd0, LAT_OP);
        add_vec(RD, 4'd13, 32'h0,        32'h0,        2'd1, LAT_OP);
        add_vec(RD, 4'd3,  32'h0,        32'hDEADBEEF, 2'd0, LAT_OP);
        add_vec(WR, 4'd12, 32'h55AA55AA, 32'h0,        2'd1, LAT_OP);
        for (int i = 0; i < int'(DEPTH); i++) begin
            add_vec(WR, 4'(i), 32'h100 + 32'(i), 32'h0, 2'd0, LAT_OP);
        end
        add_vec(RD,  4'd11, 32'h0, 32'h10B, 2'd0, LAT_OP);
        add_vec(NOP, 4'd2,  32'h0, 32'h0,   2'd0, LAT_OP);
        add_vec(CLR, 4'd15, 32'h0, 32'h0,   2'd0, LAT_CLR);
        for (int i = 0; i < int'(DEPTH); i++) begin
            add_vec(RD, 4'(i), 32'h0, 32'h0, 2'd0, LAT_OP);
        end

        // Reset.
        rst            = 1'b1;
        r_tgl          = 1'b0;
        bus.req_toggle = 1'b0;
        bus.req_op     = NOP;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        model_reset();
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            do_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_status, int'(vecs[i].exp_lat));
        end

        // Table ends with memory cleared.
        for (int i = 0; i < 16; i++) m_mem[i] = 32'd0;

        // Random traffic against the model, posted back-to-back.
        for (int n = 0; n < 80; n++) begin
            r    = int'($urandom_range(0, 15));
            op   = (r < 2) ? NOP : (r < 8) ? WR : (r < 15) ? RD : CLR;
            addr = 4'($urandom_range(0, 15));
            wd   = $urandom;
            model_req(op, addr, wd, er, es, el);
            do_req($sformatf("rnd%0d", n), op, addr, wd, er, es, el);
        end

        // Double flip during a CLEAR: one ack, overrun sticky, nothing extra.
        chk("dbl_overrun_pre", 32'(bus.overrun), 32'd0);
        old = bus.ack_toggle;
        model_req(CLR, 4'd0, 32'h0, er, es, el);
        post(CLR, 4'd0, 32'h0);
        lat = 0;
        repeat (3) begin tick(); lat++; end
        flip_only();
        repeat (2) begin tick(); lat++; end
        flip_only();
        wait_ack(old, lat);
        m_count = m_count + 16'd1;
        m_ack   = ~m_ack;
        m_ovr   = 1'b1;
        chk("dbl_lat", 32'(lat), 32'(LAT_CLR));
        chk_counts("dbl");
        repeat (10) tick();
        chk_counts("dbl_after");
        chk("dbl_busy_after", 32'(bus.busy), 32'd0);

        // Single flip while busy: pending request accepted right after RESP.
        old = bus.ack_toggle;
        post(WR, 4'd5, 32'hCAFE0005);
        m_mem[5] = 32'hCAFE0005;
        tick();
        lat = 1;
        post(RD, 4'd5, 32'h0);
        wait_ack(old, lat);
        m_count = m_count + 16'd1;
        m_ack   = ~m_ack;
        chk("pend1_lat",    32'(lat),            32'(LAT_OP));
        chk("pend1_status", 32'(bus.rsp_status), 32'd0);
        chk_counts("pend1");
        old = bus.ack_toggle;
        lat = 0;
        wait_ack(old, lat);
        m_count = m_count + 16'd1;
        m_ack   = ~m_ack;
        chk("pend2_lat",   32'(lat),      32'(LAT_OP));
        chk("pend2_rdata", bus.rsp_rdata, 32'hCAFE0005);
        chk_counts("pend2");

        // Reset in the middle of a CLEAR aborts it and wipes storage.
        do_req("pre_rst_wr", WR, 4'd11, 32'h0BADF00D, 32'h0, 2'd0, LAT_OP);
        old = bus.ack_toggle;
        post(CLR, 4'd0, 32'h0);
        repeat (5) tick();
        rst            = 1'b1;
        r_tgl          = 1'b0;
        bus.req_toggle = 1'b0;
        #2;
        model_reset();
        chk_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        tick();
        chk_reset_outputs("midrst_rel");
        do_req("post_rst_wr", WR, 4'd0, 32'h1, 32'h0, 2'd0, LAT_OP);
        do_req("post_rst_rd", RD, 4'd0, 32'h0, 32'h1, 2'd0, LAT_OP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
